// File: rtl/prio_enc_rr.sv
// rtl/prio_enc_rr.sv - registered priority encoder with fixed-priority and round-robin modes
// One-deep output register with valid/ready handshake; ptr marks where the next round-robin search starts.
module prio_enc_rr #(
   parameter int WIDTH = 8,
   parameter int IDXW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] req,
   input  logic             mode_rr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDXW-1:0]  out_idx,
   output logic [WIDTH-1:0] out_onehot,
   output logic             out_none
);

   localparam logic [IDXW-1:0] PTR_TOP = IDXW'(WIDTH - 1);

   logic [IDXW-1:0] ptr;
   logic [IDXW-1:0] fix_idx;
   logic [IDXW-1:0] rr_idx;
   logic [IDXW-1:0] win_idx;
   logic            any_req;
   logic            accept;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign any_req  = |req;
   assign win_idx  = mode_rr ? rr_idx : fix_idx;

   // Ascending scan: the last set bit seen is the highest one.
   always_comb begin
      logic [IDXW-1:0] cand;
      fix_idx = '0;
      cand    = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cand = IDXW'(i);
         if (req[cand]) fix_idx = cand;
      end
   end

   // Descending scan starting at ptr, wrapping from 0 back to WIDTH-1.
   always_comb begin
      int              j;
      logic            found;
      logic [IDXW-1:0] cand;
      rr_idx = '0;
      found  = 1'b0;
      j      = 0;
      cand   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         j = int'(ptr) - i;
         if (j < 0) j = j + WIDTH;
         cand = IDXW'(j);
         if (!found && req[cand]) begin
            rr_idx = cand;
            found  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_idx    <= '0;
         out_onehot <= '0;
         out_none   <= 1'b0;
         ptr        <= PTR_TOP;
      end else begin
         if (accept) begin
            out_valid  <= 1'b1;
            out_none   <= !any_req;
            out_idx    <= any_req ? win_idx : '0;
            out_onehot <= any_req ? (WIDTH'(1) << win_idx) : '0;
            if (mode_rr && any_req)
               ptr <= (win_idx == '0) ? PTR_TOP : win_idx - IDXW'(1);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_prio_enc_rr.sv
// tb/tb_prio_enc_rr.sv - directed self-checking bench for prio_enc_rr (WIDTH = 8)
module tb_prio_enc_rr;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] req;
   logic       mode_rr;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_idx;
   logic [7:0] out_onehot;
   logic       out_none;

   int checks = 0;
   int errors = 0;

   prio_enc_rr #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .req        (req),
      .mode_rr    (mode_rr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_idx    (out_idx),
      .out_onehot (out_onehot),
      .out_none   (out_none)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_result(input string tag, input logic [2:0] idx, input logic [7:0] oh, input logic none);
      check({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
      check({tag, "_idx"}, 64'(out_idx), 64'(idx));
      check({tag, "_onehot"}, 64'(out_onehot), 64'(oh));
      check({tag, "_none"}, 64'(out_none), 64'(none));
   endtask

   initial begin
      logic [2:0] ff_seq [9];
      logic [2:0] alt_seq [4];
      ff_seq  = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
      alt_seq = '{3'd7, 3'd0, 3'd7, 3'd0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      req       = '0;
      mode_rr   = 1'b0;
      out_ready = 1'b1;
      #2;
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_ready", 64'(in_ready), 64'(1));
      check("rst_idx", 64'(out_idx), 64'(0));
      check("rst_onehot", 64'(out_onehot), 64'(0));
      check("rst_none", 64'(out_none), 64'(0));

      // release between edges; first edge after release must accept
      #10;
      rst      = 1'b0;
      in_valid = 1'b1;
      req      = 8'b0010_1100;
      mode_rr  = 1'b0;
      tick();
      expect_result("fixed_2c", 3'd5, 8'b0010_0000, 1'b0);

      mode_rr = 1'b1;
      req     = 8'b1000_0001;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("rr81_%0d", i), 64'(out_idx), 64'(alt_seq[i]));
      end

      req = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         tick();
         check($sformatf("rrff_%0d", i), 64'(out_idx), 64'(ff_seq[i]));
         check($sformatf("rrff_oh_%0d", i), 64'(out_onehot), 64'(8'd1 << ff_seq[i]));
      end

      // ptr is 6 now; an all-zero vector must not move it
      req = 8'h00;
      tick();
      expect_result("zero", 3'd0, 8'h00, 1'b1);
      req = 8'hFF;
      tick();
      check("after_zero", 64'(out_idx), 64'(6));

      // fixed-mode accept leaves ptr at 5
      mode_rr = 1'b0;
      req     = 8'b0000_0011;
      tick();
      expect_result("fixed_03", 3'd1, 8'b0000_0010, 1'b0);
      mode_rr = 1'b1;
      req     = 8'b0100_0001;
      tick();
      expect_result("rr_41", 3'd0, 8'b0000_0001, 1'b0);

      // backpressure: result held, new vectors refused
      out_ready = 1'b0;
      req       = 8'h10;
      #1;
      check("bp_ready", 64'(in_ready), 64'(0));
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("bp_ready_%0d", i), 64'(in_ready), 64'(0));
         expect_result($sformatf("bp_hold_%0d", i), 3'd0, 8'b0000_0001, 1'b0);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 64'(in_ready), 64'(1));
      tick();
      expect_result("bp_load", 3'd4, 8'h10, 1'b0);

      // ptr is 3 with a result held; async reset pulse mid-cycle
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'(0));
      check("mid_rst_idx", 64'(out_idx), 64'(0));
      check("mid_rst_onehot", 64'(out_onehot), 64'(0));
      check("mid_rst_ready", 64'(in_ready), 64'(1));
      #2;
      rst       = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      req       = 8'hFF;
      mode_rr   = 1'b1;
      tick();
      expect_result("post_rst", 3'd7, 8'h80, 1'b0);

      // drain: consumer takes result with no new input
      in_valid = 1'b0;
      tick();
      check("drain_valid", 64'(out_valid), 64'(0));
      tick();
      check("idle_valid", 64'(out_valid), 64'(0));
      in_valid = 1'b1;
      tick();
      expect_result("idle_ptr", 3'd6, 8'h40, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
